// File: rtl/adaptive_filter_pkg.sv
// Shared types and helpers for the adaptive filter datapath blocks.
package adaptive_filter_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;

    typedef enum logic {
        IDLE,
        STREAM
    } tdl_state_t;

    // Non-negative (a - b) mod n for a, b < n, without relying on overflow.
    function automatic int unsigned wrap_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        if (a >= b) begin
            return a - b;
        end
        return a + n - b;
    endfunction

endpackage

// File: rtl/tap_regfile.sv
// Sample history storage: one synchronous write port, one combinational
// read port and a synchronous clear.
module tap_regfile
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear wins over write so a flush on an accept cycle leaves no stale sample.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tap_delay_line.sv
// Circular sample delay line feeding the tap MAC: stores the last TAPS samples
// and streams them newest-first for every accepted input.
module tap_delay_line
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int TAPS       = 8,
    parameter int IW         = $clog2(TAPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  done,
    output logic                  primed
);

    localparam logic [IW:0]   TapsW  = (IW+1)'(TAPS);
    localparam logic [IW-1:0] TapsM1 = IW'(TAPS - 1);

    tdl_state_t state_q, state_d;
    logic [IW-1:0] wp_q, wp_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW:0]   fill_q, fill_d;
    logic          done_q, done_d;
    logic          primed_q, primed_d;

    logic                  clearHistory;
    logic                  accept;
    logic                  transfer;
    logic [IW:0]           wpInc;
    logic [IW-1:0]         readAddr;
    logic [DATA_WIDTH-1:0] readData;

    assign clearHistory = !reset || flush;
    assign accept       = in_valid && in_ready;
    assign transfer     = out_valid && out_ready;
    assign wpInc        = {1'b0, wp_q} + (IW+1)'(1);
    assign readAddr     = IW'(wrap_sub(32'(wp_q), 32'(k_q), 32'(TAPS)));

    tap_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TAPS),
        .AW         (IW)
    ) u_regfile (
        .clock (clock),
        .clear (clearHistory),
        .we    (accept),
        .waddr (wp_q),
        .wdata (in_data),
        .raddr (readAddr),
        .rdata (readData)
    );

    // Enable-low freeze is folded into the next-state logic, so only clear is special here.
    always_ff @(posedge clock) begin
        if (clearHistory) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            k_q      <= '0;
            fill_q   <= '0;
            done_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            k_q      <= k_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
            primed_q <= primed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        k_d     = k_q;
        fill_d  = fill_q;
        // A pending done survives a disabled cycle and is seen once enable returns.
        done_d  = enable ? 1'b0 : done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STREAM;
                    k_d     = '0;
                    fill_d  = (fill_q == TapsW) ? fill_q : fill_q + (IW+1)'(1);
                end
            end
            STREAM: begin
                if (transfer) begin
                    if (k_q == TapsM1) begin
                        state_d = IDLE;
                        wp_d    = (wpInc == TapsW) ? '0 : wpInc[IW-1:0];
                        k_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        primed_d = (fill_d == TapsW);
    end

    // Outputs are masked to zero whenever no tap word is being offered.
    always_comb begin
        in_ready  = enable && reset && !flush && (state_q == IDLE);
        out_valid = enable && (state_q == STREAM);
        out_data  = out_valid ? readData : '0;
        out_index = out_valid ? k_q : '0;
        out_last  = out_valid && (k_q == TapsM1);
        done      = done_q && enable;
        primed    = primed_q;
    end

endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line with TAPS=4, DATA_WIDTH=8.
module tb_tap_delay_line;

    localparam int DW = 8;
    localparam int NT = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } tap_t;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          done;
    logic          primed;

    tap_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   xferCount  = 0;
    int   doneCount  = 0;
    int   xferBase;
    int   doneBase;

    tap_delay_line #(
        .DATA_WIDTH (DW),
        .TAPS       (NT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .primed    (primed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: pops on every transfer, peeks during stalls, watches handshake rules.
    always @(negedge clock) begin
        tap_t got;
        got = '{data: out_data, idx: out_index, last: out_last};
        if (done) doneCount++;
        if (out_valid) begin
            checks++;
            if (in_ready) begin
                errors++;
                $display("[TB] FAIL inReadyDuringStream actual=%0b required=0", in_ready);
            end
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedTap actual data=%h idx=%0d required no tap", out_data, out_index);
            end else if (got !== expQ[0]) begin
                errors++;
                $display("[TB] FAIL tapWord actual data=%h idx=%0d last=%0b required data=%h idx=%0d last=%0b",
                         got.data, got.idx, got.last, expQ[0].data, expQ[0].idx, expQ[0].last);
            end
            if (out_ready) begin
                xferCount++;
                if (expQ.size() != 0) void'(expQ.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d,
                                 input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                 input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        logic [DW-1:0] e [NT];
        int t;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        t = 0;
        while (!in_ready && t < 50) begin
            cycle();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL inReadyTimeout actual=0 required=1");
        end
        for (int i = 0; i < NT; i++) begin
            expQ.push_back('{data: e[i], idx: IW'(i), last: (i == NT - 1)});
        end
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (t < 50) begin
            @(negedge clock);
            if (done) break;
            t++;
        end
        checkOutput("doneSeen", done, 1);
        cycle();
        checkOutput("donePulseWidth", done, 0);
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        expQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset
        cycle();
        cycle();
        checkOutput("resetOutputs",
                    int'({in_ready, out_valid, out_data, out_index, out_last, done, primed}), 0);
        reset = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("inReadyAfterReset", in_ready, 1);
        cycle();

        // Single sample
        out_ready = 1'b1;
        xferBase  = xferCount;
        doneBase  = doneCount;
        applyStimulus(8'h11, 8'h11, 8'h00, 8'h00, 8'h00);
        waitDone();
        checkOutput("singlePrimed", primed, 0);
        checkOutput("singleTransfers", xferCount - xferBase, 4);
        checkOutput("singleDones", doneCount - doneBase, 1);

        // Wrap
        pulseFlush();
        checkOutput("flushIdlePrimed", primed, 0);
        applyStimulus(8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
        waitDone();
        applyStimulus(8'h02, 8'h02, 8'h01, 8'h00, 8'h00);
        waitDone();
        applyStimulus(8'h03, 8'h03, 8'h02, 8'h01, 8'h00);
        waitDone();
        checkOutput("primedAfter3", primed, 0);
        applyStimulus(8'h04, 8'h04, 8'h03, 8'h02, 8'h01);
        checkOutput("primedAtAccept4", primed, 1);
        waitDone();
        applyStimulus(8'h05, 8'h05, 8'h04, 8'h03, 8'h02);
        waitDone();
        checkOutput("primedAfter5", primed, 1);

        // Backpressure
        xferBase = xferCount;
        doneBase = doneCount;
        applyStimulus(8'h06, 8'h06, 8'h05, 8'h04, 8'h03);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        checkOutput("stallIndex", out_index, 1);
        cycle();
        checkOutput("stallValid", out_valid, 1);
        out_ready = 1'b1;
        waitDone();
        checkOutput("bpTransfers", xferCount - xferBase, 4);
        checkOutput("bpDones", doneCount - doneBase, 1);

        // Flush mid-stream
        doneBase = doneCount;
        applyStimulus(8'h07, 8'h07, 8'h06, 8'h05, 8'h04);
        cycle();
        cycle();
        checkOutput("flushAtIndex", out_index, 2);
        pulseFlush();
        checkOutput("flushValid", out_valid, 0);
        checkOutput("flushPrimed", primed, 0);
        for (int i = 0; i < 3; i++) cycle();
        checkOutput("flushNoDone", doneCount - doneBase, 0);
        applyStimulus(8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00);
        waitDone();

        // Enable stall
        xferBase = xferCount;
        applyStimulus(8'hBB, 8'hBB, 8'hAA, 8'h00, 8'h00);
        cycle();
        enable = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("enStallValid", out_valid, 0);
            checkOutput("enStallReady", in_ready, 0);
            cycle();
        end
        enable = 1'b1;
        #1;
        checkOutput("resumeIndex", out_index, 1);
        waitDone();
        checkOutput("enTransfers", xferCount - xferBase, 4);
        checkOutput("queueDrained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
